// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and codes for the pipeline hazard controller
//
// Contents:
//   mult_state_e : multiplier occupancy FSM encoding (IDLE / BUSY / DONE)
//   OS_HI, OS_LO : D-stage OutSelect codes that read the multiplier result
//   FWD_*        : E-stage forwarding select codes
//   reads_hilo() : true when a D-stage OutSelect reads HI or LO
//   fwd_sel()    : forwarding select for one E-stage source operand

package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_BUSY = 2'd1,
        MS_DONE = 2'd2
    } mult_state_e;

    localparam logic [1:0] OS_HI = 2'b01;
    localparam logic [1:0] OS_LO = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    function automatic logic reads_hilo(input logic [1:0] out_sel);
        return (out_sel == OS_HI) || (out_sel == OS_LO);
    endfunction

    // M has the younger value, so it wins when both later stages match.
    // Register 0 is hard-wired and never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       wr_m,
        input logic [4:0] dst_m,
        input logic       wr_w,
        input logic [4:0] dst_w
    );
        if (wr_m && (dst_m != 5'd0) && (dst_m == src)) begin
            return FWD_M;
        end else if (wr_w && (dst_w != 5'd0) && (dst_w == src)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mult_tracker.sv
// rtl/hazard_ctrl_mult_tracker.sv - multiplier occupancy countdown FSM
//
// Module mult_tracker.
// Ports:
//   clk          in  clock, rising edge
//   rst          in  asynchronous active-high reset
//   start_mult_e in  E-stage instruction starts a multiply
//   stall_e      in  D-E register is held this cycle
//   mult_busy    out multiplier occupied (state BUSY)
//   mult_done    out one-cycle completion pulse (state DONE)

module mult_tracker
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_LATENCY = 32,
    parameter int CNT_W        = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start_mult_e,
    input  logic stall_e,
    output logic mult_busy,
    output logic mult_done
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mult_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             accepted_q, accepted_d;
    logic             accept;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= MS_IDLE;
            count_q    <= '0;
            accepted_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            accepted_q <= accepted_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        accept  = start_mult_e & ~accepted_q;

        // A start held in E by a stall must only launch once; the flag
        // survives exactly as long as the D-E register keeps holding it.
        accepted_d = (accepted_q | accept) & stall_e;

        if (accept) begin
            // Also reloads from BUSY, which restarts a violated multiply.
            state_d = MS_BUSY;
            count_d = CNT_LOAD;
        end else begin
            case (state_q)
                MS_BUSY: begin
                    // Count keeps running through memory stalls; leaving
                    // BUSY as the count reaches zero gives LATENCY-1 busy
                    // cycles followed by the DONE cycle.
                    count_d = count_q - CNT_ONE;
                    if (count_q <= CNT_ONE) begin
                        state_d = MS_DONE;
                    end
                end
                MS_DONE: state_d = MS_IDLE;
                default: state_d = MS_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        mult_busy = (state_q == MS_BUSY);
        mult_done = (state_q == MS_DONE);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/forward controller for the 5-stage core
//
// Build option: HAZARD_FWD_EN enables E-stage forwarding; without it the
// forward selects are 00 and dependencies on E/M writers stall instead.
// Ports:
//   Clk, Rst                       clock, asynchronous active-high reset
//   RsD, RtD, OutSelectD, StartMultD   D-stage sources / HI-LO read / mult start
//   RsE, RtE, WriteRegE            E-stage sources and destination
//   RegWriteE, MemtoRegE, StartMultE   E-stage controls
//   PCSrcE, jumpE                  redirect resolved in E
//   WriteRegM, RegWriteM, WriteRegW, RegWriteW   later-stage writers
//   MemStall                       data-memory stall request
//   StallF/D/E/M, FlushD/E         pipeline register hold / clear controls
//   ForwardAE, ForwardBE           E-stage operand selects
//   MultBusy, MultDone             multiplier occupancy status

module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_LATENCY = 32,
    parameter int CNT_W        = 6
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [1:0] OutSelectD,
    input  logic       StartMultD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic       RegWriteE,
    input  logic       MemtoRegE,
    input  logic       StartMultE,
    input  logic       PCSrcE,
    input  logic       jumpE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemStall,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MultBusy,
    output logic       MultDone
);

    logic load_use;
    logic mult_hazard;
    logic dep_hazard;
    logic redirect;

    mult_tracker #(
        .MULT_LATENCY (MULT_LATENCY),
        .CNT_W        (CNT_W)
    ) u_mult_tracker (
        .clk          (Clk),
        .rst          (Rst),
        .start_mult_e (StartMultE),
        .stall_e      (StallE),
        .mult_busy    (MultBusy),
        .mult_done    (MultDone)
    );

    // Hazard terms
    always_comb begin
        load_use = RegWriteE & MemtoRegE & (WriteRegE != 5'd0) &
                   ((WriteRegE == RsD) | (WriteRegE == RtD));

        // StartMultE covers the cycle before the tracker reaches BUSY.
        mult_hazard = (reads_hilo(OutSelectD) | StartMultD) &
                      (MultBusy | StartMultE);

        redirect = PCSrcE | jumpE;

`ifdef HAZARD_FWD_EN
        dep_hazard = load_use;
`else
        // No bypass network: wait until the producer reaches W, where the
        // write-first register file supplies the value.
        dep_hazard = load_use |
                     (RegWriteE & (WriteRegE != 5'd0) &
                      ((WriteRegE == RsD) | (WriteRegE == RtD))) |
                     (RegWriteM & (WriteRegM != 5'd0) &
                      ((WriteRegM == RsD) | (WriteRegM == RtD)));
`endif
    end

    // Priority: reset, memory stall, redirect, dependency/multiplier
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;

        if (Rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (MemStall) begin
            // Freezing everything also defers a pending redirect: the
            // branch stays in E and is acted on once the stall drops.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (redirect) begin
            // Squashing D and E also kills any instruction that would have
            // stalled, so the redirect needs no stall of its own.
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (dep_hazard | mult_hazard) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // Forwarding selects
`ifdef HAZARD_FWD_EN
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (!Rst) begin
            ForwardAE = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
            ForwardBE = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
        end
    end
`else
    logic unused_fwd_inputs;

    always_comb begin
        ForwardAE         = FWD_RF;
        ForwardBE         = FWD_RF;
        unused_fwd_inputs = ^{RsE, RtE, WriteRegW, RegWriteW};
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl

module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {StallF, StallD, StallE, StallM, FlushD, FlushE}
    localparam logic [5:0] CTL_NONE  = 6'b000000;
    localparam logic [5:0] CTL_BUBB  = 6'b110001;
    localparam logic [5:0] CTL_FLUSH = 6'b000011;
    localparam logic [5:0] CTL_MEM   = 6'b111100;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic [1:0] OutSelectD;
    logic       StartMultD, RegWriteE, MemtoRegE, StartMultE;
    logic       PCSrcE, jumpE, RegWriteM, RegWriteW, MemStall;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       MultBusy, MultDone;
    logic [5:0] ctl;

    int n_asserts = 0;
    int n_fail    = 0;

    assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE};

    always #5 Clk = ~Clk;

    hazard_ctrl #(
        .MULT_LATENCY (4),
        .CNT_W        (6)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .RsD        (RsD),
        .RtD        (RtD),
        .OutSelectD (OutSelectD),
        .StartMultD (StartMultD),
        .RsE        (RsE),
        .RtE        (RtE),
        .WriteRegE  (WriteRegE),
        .RegWriteE  (RegWriteE),
        .MemtoRegE  (MemtoRegE),
        .StartMultE (StartMultE),
        .PCSrcE     (PCSrcE),
        .jumpE      (jumpE),
        .WriteRegM  (WriteRegM),
        .WriteRegW  (WriteRegW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .MemStall   (MemStall),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .MultBusy   (MultBusy),
        .MultDone   (MultDone)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #2;
    endtask

    task automatic clr_inputs;
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        OutSelectD = 2'b00; StartMultD = 0;
        RegWriteE = 0; MemtoRegE = 0; StartMultE = 0;
        PCSrcE = 0; jumpE = 0; RegWriteM = 0; RegWriteW = 0; MemStall = 0;
    endtask

    initial begin
        Rst = 1'b1;
        clr_inputs();
        // Requests during reset must not reach the outputs
        MemStall = 1; RegWriteM = 1; WriteRegM = 5; RsE = 5;
        tick();
        chk("rst_ctl", 8'(ctl), 8'(CTL_FLUSH));
        chk("rst_fwd_a", 8'(ForwardAE), 8'h00);
        chk("rst_busy", 8'(MultBusy), 8'h0);
        chk("rst_done", 8'(MultDone), 8'h0);
        clr_inputs();
        Rst = 1'b0;
        #1;
        chk("idle_ctl", 8'(ctl), 8'(CTL_NONE));

        // Multiply launched in E, HI/LO reads waiting in D
        tick();
        StartMultE = 1;
        #1;
        chk("mult_start_ctl", 8'(ctl), 8'(CTL_NONE));
        tick();
        StartMultE = 0; OutSelectD = 2'b01;
        #1;
        chk("mult_c1_busy", 8'(MultBusy), 8'h1);
        chk("mult_c1_ctl", 8'(ctl), 8'(CTL_BUBB));
        tick();
        OutSelectD = 2'b11;
        #1;
        chk("mult_c2_other_ctl", 8'(ctl), 8'(CTL_NONE));
        OutSelectD = 2'b01;
        #1;
        chk("mult_c2_ctl", 8'(ctl), 8'(CTL_BUBB));
        tick();
        OutSelectD = 2'b10;
        #1;
        chk("mult_c3_ctl", 8'(ctl), 8'(CTL_BUBB));
        chk("mult_c3_done", 8'(MultDone), 8'h0);
        tick();
        OutSelectD = 2'b01;
        #1;
        chk("mult_c4_done", 8'(MultDone), 8'h1);
        chk("mult_c4_busy", 8'(MultBusy), 8'h0);
        chk("mult_c4_ctl", 8'(ctl), 8'(CTL_NONE));
        tick();
        clr_inputs();
        #1;
        chk("mult_c5_done", 8'(MultDone), 8'h0);

        // Load-use: lw $8 in E, consumer in D
        RegWriteE = 1; MemtoRegE = 1; WriteRegE = 8; RsD = 8;
        #1;
        chk("lu_ctl", 8'(ctl), 8'(CTL_BUBB));
        WriteRegE = 0; RsD = 0;
        #1;
        chk("lu_reg0_ctl", 8'(ctl), 8'(CTL_NONE));
        tick();
        clr_inputs();
        RsE = 8; RegWriteM = 1; WriteRegM = 8;
        #1;
        chk("lu_fwd_a", 8'(ForwardAE), FWD ? 8'h2 : 8'h0);
        chk("lu_next_ctl", 8'(ctl), 8'(CTL_NONE));

        // ALU producer in E, consumer in D
        clr_inputs();
        RegWriteE = 1; WriteRegE = 9; RtD = 9;
        #1;
        chk("alu_dep_ctl", 8'(ctl), FWD ? 8'(CTL_NONE) : 8'(CTL_BUBB));

        // Forwarding priority and register 0
        tick();
        clr_inputs();
        RegWriteM = 1; WriteRegM = 9; RegWriteW = 1; WriteRegW = 9; RtE = 9; RsE = 3;
        #1;
        chk("fwd_mw_b", 8'(ForwardBE), FWD ? 8'h2 : 8'h0);
        chk("fwd_mw_a", 8'(ForwardAE), 8'h0);
        RegWriteM = 0;
        #1;
        chk("fwd_w_b", 8'(ForwardBE), FWD ? 8'h1 : 8'h0);
        RegWriteM = 1; WriteRegM = 0; WriteRegW = 0; RsE = 0; RtE = 0;
        #1;
        chk("fwd_r0_a", 8'(ForwardAE), 8'h0);
        chk("fwd_r0_ctl", 8'(ctl), 8'(CTL_NONE));

        // Redirect beats load-use
        clr_inputs();
        PCSrcE = 1; RegWriteE = 1; MemtoRegE = 1; WriteRegE = 8; RsD = 8;
        #1;
        chk("redir_lu_ctl", 8'(ctl), 8'(CTL_FLUSH));
        clr_inputs();
        jumpE = 1;
        #1;
        chk("jump_ctl", 8'(ctl), 8'(CTL_FLUSH));

        // Multiply held in E by a 3-cycle memory stall
        tick();
        clr_inputs();
        MemStall = 1; StartMultE = 1;
        #1;
        chk("ms_c0_ctl", 8'(ctl), 8'(CTL_MEM));
        tick();
        jumpE = 1;
        #1;
        chk("ms_c1_ctl", 8'(ctl), 8'(CTL_MEM));
        chk("ms_c1_busy", 8'(MultBusy), 8'h1);
        tick();
        #1;
        chk("ms_c2_busy", 8'(MultBusy), 8'h1);
        tick();
        MemStall = 0;
        #1;
        chk("ms_c3_ctl", 8'(ctl), 8'(CTL_FLUSH));
        chk("ms_c3_busy", 8'(MultBusy), 8'h1);
        tick();
        clr_inputs();
        #1;
        chk("ms_c4_done", 8'(MultDone), 8'h1);
        tick();
        #1;
        chk("ms_c5_done", 8'(MultDone), 8'h0);
        chk("ms_c5_busy", 8'(MultBusy), 8'h0);

        // Reset while BUSY with count=2
        StartMultE = 1;
        tick();
        StartMultE = 0;
        tick();
        #1;
        chk("ra_busy_pre", 8'(MultBusy), 8'h1);
        Rst = 1;
        #1;
        chk("ra_busy", 8'(MultBusy), 8'h0);
        chk("ra_ctl", 8'(ctl), 8'(CTL_FLUSH));
        tick();
        Rst = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ra_no_done", 8'(MultDone), 8'h0);
        end

        // Multiply in D behind a multiply entering E
        StartMultD = 1; StartMultE = 1;
        #1;
        chk("mult_mult_ctl", 8'(ctl), 8'(CTL_BUBB));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core with the multi-cycle multiplier. It detects RAW, load-use, multiplier-busy, branch/jump-redirect and memory-stall conditions, and drives the stall and flush inputs of the F/D, D/E and E/M pipeline registers. It also drives the E-stage forwarding selects and tracks multiplier occupancy with an internal countdown FSM. It is the controlling end of each pipeline register's En (hold when 1) and Clr (synchronous clear when 1) pair.

## Interface
- MULT_LATENCY, 32, cycles from an accepted multiply start until the HI/LO result is readable (≥2)
- CNT_W, 6, countdown width; must satisfy 2^CNT_W > MULT_LATENCY
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- RsD, RtD  in  5 each  D-stage source registers
- OutSelectD  in  2  D-stage result select: 01 = HI, 10 = LO (multiplier reads); 00/11 = other
- StartMultD  in  1  D-stage instruction starts a multiply
- RsE, RtE, WriteRegE  in  5 each  E-stage sources and destination
- RegWriteE, MemtoRegE, StartMultE  in  1 each  E-stage controls
- PCSrcE, jumpE  in  1 each  taken branch / jump resolved in E
- WriteRegM, WriteRegW  in  5 each; RegWriteM, RegWriteW  in  1 each
- MemStall  in  1  data-memory stall request
- StallF, StallD, StallE, StallM  out  1 each  hold the PC / F-D / D-E / E-M registers
- FlushD, FlushE  out  1 each  clear the F-D / D-E registers
- ForwardAE, ForwardBE  out  2 each  00 = register file, 01 = W result, 10 = M result
- MultBusy  out  1  multiplier occupied; MultDone  out  1  single-cycle completion pulse

## Operation
- Multiplier FSM states: IDLE, BUSY, DONE.
  - Accept a start when StartMultE=1 and the Accepted flag is clear.
  - On accept from IDLE or DONE: count ← MULT_LATENCY−1 and go to BUSY. Set Accepted.
  - Accepted clears on the first cycle with StallE=0, so an E instruction held by MemStall starts the multiply only once.
  - BUSY decrements count every cycle, including during MemStall. At count=0 go to DONE.
  - DONE lasts one cycle (MultDone=1), then IDLE unless a new start is accepted.
  - An accept while in BUSY (protocol violation) reloads the count.
- MultBusy = (state==BUSY).
- Stall and flush terms are combinational:
  - Load-use: RegWriteE & MemtoRegE & WriteRegE≠0 & (WriteRegE==RsD | WriteRegE==RtD).
  - Mult hazard: (OutSelectD∈{01,10} | StartMultD) & (state==BUSY | StartMultE).
  - Redirect: PCSrcE | jumpE.
- Priority, highest first:
  - MemStall: StallF=StallD=StallE=StallM=1; flushes 0; redirect deferred until MemStall drops.
  - Redirect: FlushD=FlushE=1; StallF=StallD=0.
  - Load-use or mult hazard: StallF=StallD=1, FlushE=1.
  - Otherwise: all stalls and flushes 0.
- Forwarding for ForwardAE (RsE); ForwardBE is identical using RtE:
  - 10 if RegWriteM & WriteRegM≠0 & WriteRegM==RsE.
  - Else 01 if RegWriteW & WriteRegW≠0 & WriteRegW==RsE.
  - Else 00. M beats W when both match. Register 0 never forwards.

## Timing
- Reset: state=IDLE, count=0, Accepted=0, MultBusy=0, MultDone=0.
  - While Rst=1: all stalls 0, FlushD=FlushE=1, ForwardAE/BE=00.
- Reset mid-multiply aborts the multiply immediately. No MultDone pulse is produced.
- A start accepted at edge N gives MultBusy=1 in cycles N+1 … N+MULT_LATENCY−1 and MultDone=1 in cycle N+MULT_LATENCY. A HI/LO read in D proceeds in that DONE cycle.
- Stall, flush and forward outputs are valid in the same cycle as their inputs (no register stage). They are registered by the pipeline registers at the next edge.
- Load-use costs exactly one bubble. Redirect costs two squashed slots.

## Configuration
- HAZARD_FWD_EN defined: forwarding as above.
- Not defined: ForwardAE/BE tied to 00. The dependency stall is extended: any RsD/RtD match against a writing, nonzero WriteRegE or WriteRegM stalls F/D and flushes E. The W stage relies on the write-first register file.

## Structure
- Shared package holds the FSM state encoding and the OutSelect codes (OS_HI=01, OS_LO=10).
- One sub-module, mult_tracker, holds the FSM, the countdown and the Accepted flag. The top level holds the combinational priority and forwarding logic.

## Test plan
- MULT_LATENCY=4: StartMultE at edge 0, then mfhi in D at cycles 1–3 → StallF=StallD=FlushE=1 in cycles 1–3. MultDone=1 and no stall in cycle 4.
- lw $t0 in E with RsD=8 → one cycle of StallF=StallD=FlushE=1. Next cycle RsE=8 with M writing 8 → ForwardAE=10.
- M and W both write reg 9 and RtE=9 → ForwardBE=10. WriteRegM=0 with RsE=0 → ForwardAE=00.
- PCSrcE=1 together with a load-use condition → FlushD=FlushE=1, StallF=StallD=0.
- MemStall held 3 cycles with StartMultE=1 → exactly one accept, and MultDone 4 cycles after the first accept. jumpE asserted during MemStall flushes only after the stall drops.
- Rst pulsed while BUSY with count=2 → MultBusy=0 immediately, and MultDone never pulses.
